// File: rtl/strobe_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// strobe_bus_pkg : shared states, widths and response codes for strobe-bus initiators
// Revision: 1.0
// ----------------------------------------------------------------------------
package strobe_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Value carried on the response error flag
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_bus_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// strobe_bus_master_if : host request/response port plus strobe/ack bus wires
// Revision: 1.0
// ----------------------------------------------------------------------------
interface strobe_bus_master_if;
  import strobe_bus_pkg::*;

  // Host side
  logic              iREQ;
  logic              iREQ_WE;
  logic [ADDR_W-1:0] iREQ_ADR;
  logic [DATA_W-1:0] iREQ_WDAT;
  logic              oREQ_RDY;
  logic              oRSP_VLD;
  logic [DATA_W-1:0] oRSP_RDAT;
  logic              oRSP_ERR;

  // Responder side
  logic              oSTB;
  logic              oWE;
  logic [ADDR_W-1:0] oADR;
  logic [DATA_W-1:0] oDAT;
  logic [DATA_W-1:0] iDAT;
  logic              iACK;

  modport master (
    input  iREQ, iREQ_WE, iREQ_ADR, iREQ_WDAT, iDAT, iACK,
    output oREQ_RDY, oRSP_VLD, oRSP_RDAT, oRSP_ERR, oSTB, oWE, oADR, oDAT
  );

  modport slave (
    output iREQ, iREQ_WE, iREQ_ADR, iREQ_WDAT, iDAT, iACK,
    input  oREQ_RDY, oRSP_VLD, oRSP_RDAT, oRSP_ERR, oSTB, oWE, oADR, oDAT
  );

endinterface
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_timeout_cnt : load-to-zero / increment counter flagging TIMEOUT-1 reached
// Revision: 1.0
// ----------------------------------------------------------------------------
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  wire logic iCLK,
  input  wire logic iRST,
  input  wire logic i_load,
  input  wire logic i_inc,
  output logic      o_tc
);

  localparam int               CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at the terminal value so it can never wrap
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/strobe_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// strobe_bus_master : single-outstanding strobe/ack bus initiator with timeout
// Revision: 1.0
// ----------------------------------------------------------------------------
module strobe_bus_master
  import strobe_bus_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] RST_RDAT = '0
) (
  input  wire logic           iCLK,
  input  wire logic           iRST,
  strobe_bus_master_if.master bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_req_rdy;
  logic              r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_rdat;
  logic              r_rsp_err;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;

  logic              w_req_rdy;
  logic              w_rsp_vld;
  logic [DATA_W-1:0] w_rsp_rdat;
  logic              w_rsp_err;
  logic              w_stb;
  logic              w_we;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dat;

  logic              w_load;
  logic              w_inc;
  logic              w_tc;

  assign w_load = (r_state == IDLE) && bus.iREQ;
  assign w_inc  = (r_state == STRB) && !bus.iACK;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .i_load (w_load),
    .i_inc  (w_inc),
    .o_tc   (w_tc)
  );

  // State and output registers; outputs are loaded from their next-state decode
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state    <= IDLE;
      r_req_rdy  <= 1'b1;
      r_rsp_vld  <= 1'b0;
      r_rsp_rdat <= RST_RDAT;
      r_rsp_err  <= RSP_OK;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_rdy  <= w_req_rdy;
      r_rsp_vld  <= w_rsp_vld;
      r_rsp_rdat <= w_rsp_rdat;
      r_rsp_err  <= w_rsp_err;
      r_stb      <= w_stb;
      r_we       <= w_we;
      r_adr      <= w_adr;
      r_dat      <= w_dat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.iREQ) w_state_nxt = STRB;
      STRB:    if (bus.iACK || w_tc) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req_rdy  = (w_state_nxt == IDLE);
    w_rsp_vld  = (w_state_nxt == RESP);
    w_stb      = (w_state_nxt == STRB);
    w_we       = 1'b0;
    w_adr      = '0;
    w_dat      = '0;
    w_rsp_rdat = r_rsp_rdat;
    w_rsp_err  = r_rsp_err;

    // The bus registers double as the request latch while strobing
    if (w_state_nxt == STRB) begin
      if (r_state == IDLE) begin
        w_we  = bus.iREQ_WE;
        w_adr = bus.iREQ_ADR;
        w_dat = bus.iREQ_WDAT;
      end else begin
        w_we  = r_we;
        w_adr = r_adr;
        w_dat = r_dat;
      end
    end

    // Ack wins over timeout; iDAT is only looked at on an acked read
    if (r_state == STRB) begin
      if (bus.iACK) begin
        w_rsp_rdat = r_we ? RST_RDAT : bus.iDAT;
        w_rsp_err  = RSP_OK;
      end else if (w_tc) begin
        w_rsp_rdat = RST_RDAT;
        w_rsp_err  = RSP_TIMEOUT;
      end
    end
  end

  assign bus.oREQ_RDY  = r_req_rdy;
  assign bus.oRSP_VLD  = r_rsp_vld;
  assign bus.oRSP_RDAT = r_rsp_rdat;
  assign bus.oRSP_ERR  = r_rsp_err;
  assign bus.oSTB      = r_stb;
  assign bus.oWE       = r_we;
  assign bus.oADR      = r_adr;
  assign bus.oDAT      = r_dat;

endmodule
`default_nettype wire

// File: doc/strobe_bus_master.md
# strobe_bus_master

Single-outstanding-transaction initiator for the on-chip strobe/acknowledge register bus (iSTB/iWE/iADR/oDAT/oACK). It accepts one read or write request from a host port and drives the bus until the responder acknowledges or a timeout expires. It then returns read data and an error flag on a one-cycle response pulse. It sits between a host (test sequencer or CPU shim) and address-decoded responders such as the constant/ID register block.

## Interface
- TIMEOUT, 16: max strobe cycles without ack before error; legal range ≥1
- RST_RDAT, 32'h0000_0000: value of oRSP_RDAT after reset, on writes, and on errors
- iCLK  in  1  clock, all logic on rising edge
- iRST  in  1  synchronous reset, active-low
- iREQ  in  1  host request; sampled only when oREQ_RDY=1
- iREQ_WE  in  1  1=write, 0=read
- iREQ_ADR  in  32  request address
- iREQ_WDAT  in  32  write data
- oREQ_RDY  out  1  idle, request will be accepted this cycle
- oRSP_VLD  out  1  one-cycle response pulse
- oRSP_RDAT  out  32  read data, valid with oRSP_VLD
- oRSP_ERR  out  1  timeout flag, valid with oRSP_VLD
- oSTB  out  1  bus strobe (drives responder iSTB)
- oWE  out  1  bus write enable
- oADR  out  32  bus address
- oDAT  out  32  bus write data
- iDAT  in  32  bus read data; may be high-Z when not acked, sampled only on iACK & ~oWE
- iACK  in  1  responder acknowledge

## Operation
- FSM states: IDLE, STRB, RESP; reset state IDLE.
- IDLE: oREQ_RDY=1. On iREQ=1, latch WE/ADR/WDAT and load the timeout counter with 0. Next state STRB.
- STRB: oSTB=1, and oWE/oADR/oDAT carry the latched request. Each cycle:
  - iACK=1: capture iDAT into oRSP_RDAT if read (RST_RDAT if write), ERR=0, go to RESP.
  - else if counter==TIMEOUT-1: RDAT=RST_RDAT, ERR=1, go to RESP.
  - else increment counter.
  - Ack takes priority over timeout in the same cycle.
- RESP: oRSP_VLD=1, oSTB=0. Next state IDLE.
- oSTB=0 implies oWE=0, oADR=0, oDAT=0 (clean bus when idle).
- iREQ outside IDLE is ignored; there is no queuing. The host must hold or reissue the request.
- oRSP_RDAT and oRSP_ERR hold their values until the next RESP.
- Counter width is $clog2(TIMEOUT+1); it never wraps.

## Timing
- All outputs are registered.
- Reset values: oREQ_RDY=1, oRSP_VLD=0, oRSP_RDAT=RST_RDAT, oRSP_ERR=0, oSTB=0, oWE=0, oADR=0, oDAT=0.
- Request accepted at edge N (iREQ & oREQ_RDY): oSTB high from cycle N+1.
- Zero-wait responder (ack in first strobe cycle): oRSP_VLD in cycle N+2, oREQ_RDY again in cycle N+3. Minimum request spacing is 3 cycles.
- Responder acks after k wait cycles (k<TIMEOUT): oRSP_VLD in cycle N+2+k.
- No ack: oSTB high exactly TIMEOUT cycles (N+1..N+TIMEOUT), then oRSP_VLD with ERR=1 in cycle N+TIMEOUT+1.
- Reset asserted mid-transaction: on the next edge all outputs take reset values and the transaction is dropped with no response pulse.
- oREQ_RDY and oRSP_VLD are never high in the same cycle.

## Structure
- Shared package `strobe_bus_pkg`:
  - state enum (IDLE/STRB/RESP)
  - bus width constants (ADDR_W=32, DATA_W=32)
  - response error code constants
- One sub-module, `bus_timeout_cnt`: load/increment/terminal-count counter parameterized by TIMEOUT, reused by later initiators.
- Top contains the FSM, request latch and response registers.

## Test plan
- Read hit: responder with 0x0200_0100→0x0123_4567 (zero-wait). Request read 0x0200_0100 at cycle N. Required: oSTB=1 in N+1, oRSP_VLD in N+2, RDAT=0x0123_4567, ERR=0.
- Back-to-back reads 0x0200_0104 then 0x0200_0108, with iREQ held high. Required: RDAT 0x89AB_CDEF then 0xFEDC_BA98, 3-cycle spacing, oREQ_RDY low between.
- Unmapped read 0x0200_0110, TIMEOUT=16. Required: oSTB high 16 cycles, oRSP_VLD with ERR=1, RDAT=0, iDAT high-Z never captured.
- Write 0x0200_0100 data 0xDEAD_BEEF. Required: oWE=1 and oDAT=0xDEAD_BEEF during strobe, response RDAT=0, ERR=0.
- Late ack: responder acks on strobe cycle 16 (exactly at the timeout boundary). Required: ERR=0, data captured; ack on cycle 17 is never seen.
- iRST=0 in 3rd strobe cycle of a timing-out read. Required: next cycle oSTB=0, oREQ_RDY=1, no oRSP_VLD ever for that request.
